// File: rtl/shift_unit_if.sv
// Bundle of the two requester channels and the result channel of the shared
// shift unit. The clients and consumer drive "master"; the arbiter uses "slave".
interface shift_unit_if;
    logic        req0_valid;
    logic        req0_ready;
    logic [31:0] req0_data;
    logic [4:0]  req0_shamt;
    logic [1:0]  req0_op;

    logic        req1_valid;
    logic        req1_ready;
    logic [31:0] req1_data;
    logic [4:0]  req1_shamt;
    logic [1:0]  req1_op;

    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic        out_id;
    logic        out_err;

    modport master (
        output req0_valid, req0_data, req0_shamt, req0_op,
        output req1_valid, req1_data, req1_shamt, req1_op,
        output out_ready,
        input  req0_ready, req1_ready,
        input  out_valid, out_result, out_id, out_err
    );

    modport slave (
        input  req0_valid, req0_data, req0_shamt, req0_op,
        input  req1_valid, req1_data, req1_shamt, req1_op,
        input  out_ready,
        output req0_ready, req1_ready,
        output out_valid, out_result, out_id, out_err
    );
endinterface

// File: rtl/shift_unit_arbiter.sv
// Shares one 32-bit SLL/SRL/SRA datapath between two requesters.
// Round-robin grant in S_IDLE, one registered shift cycle in S_EXEC, and the
// tagged result held in S_DONE until the consumer takes it.
module shift_unit_arbiter (
    input  logic         clk,
    input  logic         rst,
    shift_unit_if.slave  bus
);
    localparam int N   = 32;
    localparam int SHW = $clog2(N);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic             last_grant_q, last_grant_d;
    logic [N-1:0]     data_q, data_d;
    logic [SHW-1:0]   shamt_q, shamt_d;
    logic [1:0]       op_q, op_d;
    logic             id_q, id_d;
    logic [N-1:0]     out_result_q, out_result_d;
    logic             out_id_q, out_id_d;
    logic             out_err_q, out_err_d;

    logic             grant_any;
    logic             grant_id;
    logic [N-1:0]     sll_res;
    logic [N-1:0]     srl_res;
    logic [N-1:0]     sra_res;
    logic [N-1:0]     shift_sel;

    // Round-robin pick: a lone requester wins; on a tie the one not served last wins.
    always_comb begin
        grant_any = bus.req0_valid | bus.req1_valid;
        if (bus.req0_valid && bus.req1_valid) begin
            grant_id = ~last_grant_q;
        end else begin
            grant_id = bus.req1_valid;
        end
    end

    // The three shifters always look at the captured operands; op selects one.
    assign sll_res = data_q << shamt_q;
    assign srl_res = data_q >> shamt_q;
    assign sra_res = $unsigned($signed(data_q) >>> shamt_q);

    // Op decode; the illegal encoding passes the operand through untouched.
    always_comb begin
        case (op_q)
            2'b00:   shift_sel = sll_res;
            2'b01:   shift_sel = srl_res;
            2'b11:   shift_sel = sra_res;
            default: shift_sel = data_q;
        endcase
    end

    // Next-state, capture and result loading; ready is combinational and only in idle.
    always_comb begin
        state_d       = state_q;
        last_grant_d  = last_grant_q;
        data_d        = data_q;
        shamt_d       = shamt_q;
        op_d          = op_q;
        id_d          = id_q;
        out_result_d  = out_result_q;
        out_id_d      = out_id_q;
        out_err_d     = out_err_q;
        bus.req0_ready = 1'b0;
        bus.req1_ready = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (grant_any && !rst) begin
                    bus.req0_ready = ~grant_id;
                    bus.req1_ready = grant_id;
                    data_d         = grant_id ? bus.req1_data  : bus.req0_data;
                    shamt_d        = grant_id ? bus.req1_shamt : bus.req0_shamt;
                    op_d           = grant_id ? bus.req1_op    : bus.req0_op;
                    id_d           = grant_id;
                    last_grant_d   = grant_id;
                    state_d        = S_EXEC;
                end
            end
            S_EXEC: begin
                out_result_d = shift_sel;
                out_id_d     = id_q;
                out_err_d    = (op_q == 2'b10);
                state_d      = S_DONE;
            end
            S_DONE: begin
                if (bus.out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers; reset discards any in-flight operation.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            last_grant_q <= 1'b1;
            data_q       <= '0;
            shamt_q      <= '0;
            op_q         <= '0;
            id_q         <= 1'b0;
            out_result_q <= '0;
            out_id_q     <= 1'b0;
            out_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            data_q       <= data_d;
            shamt_q      <= shamt_d;
            op_q         <= op_d;
            id_q         <= id_d;
            out_result_q <= out_result_d;
            out_id_q     <= out_id_d;
            out_err_q    <= out_err_d;
        end
    end

    assign bus.out_valid  = (state_q == S_DONE);
    assign bus.out_result = out_result_q;
    assign bus.out_id     = out_id_q;
    assign bus.out_err    = out_err_q;
endmodule
